// File: rtl/knn_stream_feeder.sv
// knn_stream_feeder: front-end transmitter for the kNN core.
// Takes one upstream word stream (reference point, then data points), buffers
// the reference, releases each data point only once fully buffered so it goes
// out as an unbroken frame of numberOfDimensions cycles, names points
// sequentially and pulses done once the last point has drained through the core.
//
// Ports:
//   clk, reset (async, active-low), start (job start pulse)
//   s_valid/s_ready/s_data/s_last : upstream word stream
//   refDataOut/loadRef            : reference replay to the core (seeded frames)
//   dataNameOut/dataValueOut      : point name and current dimension word
//   frameValid                    : high on every emitted word
//   done/busy/protoErr            : job status
//   pointCount                    : points emitted this job
//
// Optional feature: define KNN_FEEDER_POINTCOUNT_EN to build the pointCount
// counter; otherwise pointCount is tied to 0.
// drainCycles must be >= 2: the single WAIT_POINT cycle after the last frame
// counts as the first drain cycle.
module knn_stream_feeder #(
  parameter int unsigned dataWidth          = 32,
  parameter int unsigned numberOfDimensions = 32,
  parameter int unsigned drainCycles        = 8,
  parameter int unsigned bufLog2            = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_last,
  output logic [dataWidth-1:0] refDataOut,
  output logic                 loadRef,
  output logic [31:0]          dataNameOut,
  output logic [dataWidth-1:0] dataValueOut,
  output logic                 frameValid,
  output logic                 done,
  output logic                 busy,
  output logic                 protoErr,
  output logic [31:0]          pointCount
);

  localparam int unsigned dimW      = (numberOfDimensions > 1) ? $clog2(numberOfDimensions) : 1;
  localparam int unsigned depth     = 1 << bufLog2;
  localparam int unsigned cntW      = bufLog2 + 1;
  localparam int unsigned drainW    = (drainCycles > 2) ? $clog2(drainCycles) : 1;
  localparam int unsigned drainLast = (drainCycles >= 2) ? drainCycles - 2 : 0;

  localparam logic [dimW-1:0]   dimLast   = dimW'(numberOfDimensions - 1);
  localparam logic [cntW-1:0]   cntN      = cntW'(numberOfDimensions);
  localparam logic [cntW-1:0]   cntDepth  = cntW'(depth);
  localparam logic [drainW-1:0] drainStop = drainW'(drainLast);

  typedef enum logic [2:0] {IDLE, LOAD_REF, WAIT_POINT, EMIT, DRAIN, DONE} stateT;

  stateT state, stateNext;

  logic [dataWidth-1:0] refBuf  [numberOfDimensions];
  logic [dataWidth-1:0] fifoMem [depth];

  logic [dimW-1:0]      refIdx, refIdxNext;
  logic [dimW-1:0]      inIdx, inIdxNext;
  logic [dimW-1:0]      outIdx, outIdxNext, outIdxInc;
  logic [bufLog2-1:0]   wrPtr, rdPtr;
  logic [cntW-1:0]      fifoCount, countNext;
  logic                 lastAccepted, lastAccNext;
  logic                 seeded, seededNext;
  logic [drainW-1:0]    drainCnt, drainCntNext;
  logic [31:0]          nameCnt, nameNext;

  logic                 sReadyNext, busyNext, protoErrNext, doneNext;
  logic                 frameValidNext, loadRefNext;
  logic [dataWidth-1:0] refDataNext, dataValueNext;
  logic [31:0]          dataNameNext;

  logic                 xfer, refWr, fifoWr, fifoRd, frameStart;

  assign xfer      = s_valid & s_ready;
  assign outIdxInc = outIdx + dimW'(1);

  // Next-state, datapath control and registered-output values.
  always_comb begin
    stateNext      = state;
    refIdxNext     = refIdx;
    inIdxNext      = inIdx;
    outIdxNext     = outIdx;
    lastAccNext    = lastAccepted;
    seededNext     = seeded;
    drainCntNext   = drainCnt;
    nameNext       = nameCnt;
    busyNext       = busy;
    protoErrNext   = protoErr;
    doneNext       = 1'b0;
    frameValidNext = 1'b0;
    loadRefNext    = 1'b0;
    refDataNext    = '0;
    dataValueNext  = '0;
    dataNameNext   = '0;
    sReadyNext     = 1'b0;
    refWr          = 1'b0;
    fifoWr         = 1'b0;
    fifoRd         = 1'b0;
    frameStart     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext    = LOAD_REF;
          busyNext     = 1'b1;
          nameNext     = '0;
          protoErrNext = 1'b0;
          lastAccNext  = 1'b0;
          refIdxNext   = '0;
          inIdxNext    = '0;
        end
      end
      LOAD_REF: begin
        if (xfer) begin
          refWr = 1'b1;
          if (s_last) protoErrNext = 1'b1;
          if (refIdx == dimLast) begin
            refIdxNext = '0;
            stateNext  = WAIT_POINT;
          end else begin
            refIdxNext = refIdx + dimW'(1);
          end
        end
      end
      WAIT_POINT: begin
        if (fifoCount >= cntN) begin
          stateNext  = EMIT;
          seededNext = 1'b1;
          frameStart = 1'b1;
        end else if (lastAccepted && fifoCount == '0) begin
          stateNext    = DRAIN;
          drainCntNext = '0;
        end
      end
      EMIT: begin
        if (outIdx == dimLast) begin
          nameNext = nameCnt + 32'd1;
          // Back-to-back frames keep the core's recirculated reference aligned.
          if (fifoCount >= cntN) begin
            seededNext = 1'b0;
            frameStart = 1'b1;
          end else begin
            stateNext = WAIT_POINT;
          end
        end else begin
          fifoRd         = 1'b1;
          outIdxNext     = outIdxInc;
          frameValidNext = 1'b1;
          loadRefNext    = seeded;
          refDataNext    = seeded ? refBuf[outIdxInc] : '0;
          dataValueNext  = fifoMem[rdPtr];
          dataNameNext   = dataNameOut;
        end
      end
      DRAIN: begin
        if (drainCnt == drainStop) begin
          stateNext = DONE;
          doneNext  = 1'b1;
        end else begin
          drainCntNext = drainCnt + drainW'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
      default: stateNext = IDLE;
    endcase

    // First word of a frame: pop and present dimension 0.
    if (frameStart) begin
      fifoRd         = 1'b1;
      outIdxNext     = '0;
      frameValidNext = 1'b1;
      loadRefNext    = seededNext;
      refDataNext    = seededNext ? refBuf[0] : '0;
      dataValueNext  = fifoMem[rdPtr];
      dataNameNext   = nameNext;
    end

    // Point intake; s_last only terminates on the last dimension of a point.
    if ((state == WAIT_POINT || state == EMIT) && xfer) begin
      fifoWr = 1'b1;
      if (inIdx == dimLast) begin
        inIdxNext = '0;
        if (s_last) lastAccNext = 1'b1;
      end else begin
        inIdxNext = inIdx + dimW'(1);
        if (s_last) protoErrNext = 1'b1;
      end
    end

    countNext = fifoCount + cntW'(fifoWr) - cntW'(fifoRd);

    // s_ready is registered, so it is derived from next-cycle state.
    case (stateNext)
      LOAD_REF:         sReadyNext = 1'b1;
      WAIT_POINT, EMIT: sReadyNext = (countNext != cntDepth) && !lastAccNext;
      default:          sReadyNext = 1'b0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      refIdx       <= '0;
      inIdx        <= '0;
      outIdx       <= '0;
      wrPtr        <= '0;
      rdPtr        <= '0;
      fifoCount    <= '0;
      lastAccepted <= 1'b0;
      seeded       <= 1'b0;
      drainCnt     <= '0;
      nameCnt      <= '0;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      protoErr     <= 1'b0;
      done         <= 1'b0;
      frameValid   <= 1'b0;
      loadRef      <= 1'b0;
      refDataOut   <= '0;
      dataValueOut <= '0;
      dataNameOut  <= '0;
    end else begin
      state        <= stateNext;
      refIdx       <= refIdxNext;
      inIdx        <= inIdxNext;
      outIdx       <= outIdxNext;
      if (fifoWr) wrPtr <= wrPtr + bufLog2'(1);
      if (fifoRd) rdPtr <= rdPtr + bufLog2'(1);
      fifoCount    <= countNext;
      lastAccepted <= lastAccNext;
      seeded       <= seededNext;
      drainCnt     <= drainCntNext;
      nameCnt      <= nameNext;
      s_ready      <= sReadyNext;
      busy         <= busyNext;
      protoErr     <= protoErrNext;
      done         <= doneNext;
      frameValid   <= frameValidNext;
      loadRef      <= loadRefNext;
      refDataOut   <= refDataNext;
      dataValueOut <= dataValueNext;
      dataNameOut  <= dataNameNext;
    end
  end

  // Reference buffer and point FIFO storage.
  always_ff @(posedge clk) begin
    if (refWr)  refBuf[refIdx] <= s_data;
    if (fifoWr) fifoMem[wrPtr] <= s_data;
  end

`ifdef KNN_FEEDER_POINTCOUNT_EN
  logic [31:0] pointCnt;

  // Counts frames on their last word; cleared when a job starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pointCnt <= '0;
    end else if (state == IDLE && start) begin
      pointCnt <= '0;
    end else if (state == EMIT && outIdx == dimLast) begin
      pointCnt <= pointCnt + 32'd1;
    end
  end

  assign pointCount = pointCnt;
`else
  assign pointCount = '0;
`endif

endmodule

// File: doc/knn_stream_feeder.md
Name: knn_stream_feeder

Overview:
- Front-end transmitter for the kNN core: accepts one upstream word stream and drives the core's dimension-serial inputs (refDataIn, loadRef, dataNameIn, dataValueIn, done).
- Buffers the reference point, then releases each data point only when it is fully buffered, so every point goes out as an unbroken frame of numberOfDimensions cycles.
- Assigns sequential point names and issues done after the last point has drained through the core.

Parameters:
- dataWidth, 32, width of one dimension word.
- numberOfDimensions, 32, words per point (N); must be >= 2.
- drainCycles, 8, cycles from the last emitted word to the done pulse; must cover core latency.
- bufLog2, 6, point FIFO depth is 2^bufLog2 words; must be >= 2*N.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a job; ignored while busy=1.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  upstream word ready; a transfer occurs when s_valid & s_ready.
- s_data  in  dataWidth  upstream word.
- s_last  in  1  marks the last word of the last data point of the job.
- refDataOut  out  dataWidth  reference word to the core; 0 when loadRef=0.
- loadRef  out  1  high for every cycle of a seeded frame.
- dataNameOut  out  32  name of the point being emitted; held for the whole frame.
- dataValueOut  out  dataWidth  current dimension word of the point.
- frameValid  out  1  high on every emitted word.
- done  out  1  one-cycle pulse at job end.
- busy  out  1  high from start until the done cycle inclusive.
- protoErr  out  1  sticky protocol error; cleared by start.
- pointCount  out  32  points emitted this job (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, FIFO emptied, all counters cleared, every output 0 (including s_ready=0 and busy=0). Reset asserted mid-job aborts the job with no done pulse.
- States: IDLE, LOAD_REF, WAIT_POINT, EMIT, DRAIN, DONE.
- IDLE:
  - start -> LOAD_REF, busy=1, name counter=0, protoErr=0.
- LOAD_REF:
  - s_ready=1.
  - The first N transfers are stored in the reference buffer at index 0..N-1; nothing is emitted.
  - After the Nth transfer -> WAIT_POINT.
  - s_last seen in this state sets protoErr; the word is still stored as a reference word.
- Point intake (WAIT_POINT, EMIT):
  - Words enter the FIFO. s_ready = !fifoFull & !lastAccepted.
  - A dimension index counts the accepted words mod N.
  - s_last is honoured only when the index = N-1; this sets lastAccepted. At any other index, s_last sets protoErr and is ignored.
  - Simultaneous FIFO read and write is allowed; the count stays constant.
- WAIT_POINT:
  - When fifoCount >= N at a clock edge -> EMIT, and the frame is seeded.
  - When lastAccepted=1 and fifoCount=0 -> DRAIN.
  - The first word is visible on the outputs 2 cycles after the cycle in which the point's Nth word is accepted.
- EMIT:
  - Each frame pops N words on consecutive cycles; outputs are registered and frameValid=1.
  - dataNameOut = name counter, held for the whole frame.
  - Seeded frame: loadRef=1 and refDataOut = ref[d] for d = 0..N-1.
  - Unseeded frame: loadRef=0 and refDataOut=0.
  - On the final word:
    - The name counter increments, wrapping at 2^32.
    - If fifoCount >= N after this frame's reads -> next frame starts the following cycle, unseeded, with no gap.
    - Otherwise -> WAIT_POINT; the next frame is seeded so the core re-aligns its recirculated reference.
- DRAIN:
  - All outputs idle (frameValid=0, loadRef=0, refDataOut=0) for drainCycles cycles -> DONE.
- DONE:
  - done=1 for one cycle, then busy=0 -> IDLE.
- A job with zero data points (s_last never valid) is not terminated by this block.

Optional Feature:
- Macro KNN_FEEDER_POINTCOUNT_EN.
- Defined: pointCount increments on the last word of each frame, is cleared by start, and holds its value after done.
- Undefined: pointCount is tied to 0 and no counter is synthesized.

Test Plan:
- N=4: start, then reference 1,2,3,4, then point 10,20,30,40 (s_last on 40), s_valid held high -> one frame of 10,20,30,40, loadRef=1 with ref 1,2,3,4, name 0; done exactly drainCycles+1 cycles after the word 40 is emitted.
- N=4: three points streamed back-to-back with no source stalls -> 12 consecutive frameValid cycles, names 0,0,0,0,1,1,1,1,2,2,2,2, loadRef high only on the first 4.
- N=4: 5-cycle source stall in the middle of point 1 -> frameValid gap, point 1 emitted seeded (loadRef=1, ref replayed), name 1.
- N=4: s_last on dimension index 1 -> protoErr=1, word ignored as a terminator; the job ends at the next s_last on index 3.
- Reset pulled low mid-EMIT -> all outputs 0 immediately, s_ready=0, no done; a new start then runs a clean job with names from 0.
- KNN_FEEDER_POINTCOUNT_EN defined, 5 points -> pointCount=5 at done; macro undefined -> pointCount stays 0.
